// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 32-bit ALU: valid/ready handshakes on both sides,
// load-use bubble insertion, MEM/WB operand forwarding, flush and a saturating stall counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic             id_use_rs2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_use_imm,
    input  logic [2:0]       id_alu_op,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [2:0]       ex_op,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [XLEN-1:0]  mem_result,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_result,
    output logic [CNT_W-1:0] stall_count
);

    logic             valid_reg;
    logic [4:0]       rs_reg      [2];
    logic [XLEN-1:0]  rs_data_reg [2];
    logic [XLEN-1:0]  imm_reg;
    logic             use_imm_reg;
    logic [2:0]       op_reg;
    logic [4:0]       rd_reg;
    logic             reg_write_reg;
    logic             mem_read_reg;
    logic             mem_write_reg;
    logic [CNT_W-1:0] stall_count_reg;

    logic [4:0]       id_rs        [2];
    logic [XLEN-1:0]  id_rs_data   [2];
    logic [XLEN-1:0]  fwd_data     [2];
    logic [XLEN-1:0]  capture_data [2];

    logic hazard;
    logic load;
    logic drain;
    logic hold;
    logic stall_inc;

    assign id_rs[0]      = id_rs1;
    assign id_rs[1]      = id_rs2;
    assign id_rs_data[0] = id_rs1_data;
    assign id_rs_data[1] = id_rs2_data;

    // Per-source forwarding: the output mux sees MEM before WB; capture only needs WB
    // because that is the register-file write landing in the same cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic mem_hit;
            logic wb_hit;
            logic wb_capture_hit;

            assign mem_hit = mem_reg_write && (mem_rd == rs_reg[gi]) && (rs_reg[gi] != 5'd0);
            assign wb_hit  = wb_reg_write && (wb_rd == rs_reg[gi]) && (rs_reg[gi] != 5'd0);
            assign wb_capture_hit = wb_reg_write && (wb_rd == id_rs[gi]) && (id_rs[gi] != 5'd0);

            assign fwd_data[gi]     = mem_hit ? mem_result :
                                      wb_hit  ? wb_result  : rs_data_reg[gi];
            assign capture_data[gi] = wb_capture_hit ? wb_result : id_rs_data[gi];
        end
    endgenerate

    assign hazard = valid_reg && mem_read_reg && (rd_reg != 5'd0) &&
                    ((rd_reg == id_rs1) || (id_use_rs2 && (rd_reg == id_rs2)));

    assign id_ready  = !rst && !flush && !hazard && (!valid_reg || ex_ready);
    assign load      = id_valid && id_ready;
    assign drain     = valid_reg && ex_ready && !load;
    assign hold      = valid_reg && !ex_ready;
    assign stall_inc = id_valid && hazard && !flush && !(&stall_count_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg       <= 1'b0;
            rs_reg[0]       <= '0;
            rs_reg[1]       <= '0;
            rs_data_reg[0]  <= '0;
            rs_data_reg[1]  <= '0;
            imm_reg         <= '0;
            use_imm_reg     <= 1'b0;
            op_reg          <= '0;
            rd_reg          <= '0;
            reg_write_reg   <= 1'b0;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            stall_count_reg <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else begin
            if (load) begin
                valid_reg      <= 1'b1;
                rs_reg[0]      <= id_rs1;
                rs_reg[1]      <= id_rs2;
                rs_data_reg[0] <= capture_data[0];
                rs_data_reg[1] <= capture_data[1];
                imm_reg        <= id_imm;
                use_imm_reg    <= id_use_imm;
                op_reg         <= id_alu_op;
                rd_reg         <= id_rd;
                reg_write_reg  <= id_reg_write;
                mem_read_reg   <= id_mem_read;
                mem_write_reg  <= id_mem_write;
            end else if (drain) begin
                valid_reg <= 1'b0;
            end else if (hold) begin
                // Keep forwarded values alive once their producer retires from MEM/WB.
                rs_data_reg[0] <= fwd_data[0];
                rs_data_reg[1] <= fwd_data[1];
            end
            if (stall_inc) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
        end
    end

    assign ex_valid      = valid_reg;
    assign ex_a          = valid_reg ? fwd_data[0] : '0;
    assign ex_b          = !valid_reg ? '0 : (use_imm_reg ? imm_reg : fwd_data[1]);
    assign ex_store_data = valid_reg ? fwd_data[1] : '0;
    assign ex_op         = valid_reg ? op_reg : 3'd0;
    assign ex_rd         = valid_reg ? rd_reg : 5'd0;
    assign ex_reg_write  = valid_reg && reg_write_reg;
    assign ex_mem_read   = valid_reg && mem_read_reg;
    assign ex_mem_write  = valid_reg && mem_write_reg;
    assign stall_count   = stall_count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a 2-bit stall counter checks saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_rs2, id_use_imm, id_reg_write, id_mem_read, id_mem_write;
    logic [2:0]  id_alu_op;
    logic        ex_ready, ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [2:0]  ex_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic [15:0] stall_count;

    logic        s_id_ready, s_ex_valid;
    logic [31:0] s_ex_a, s_ex_b, s_ex_store_data;
    logic [2:0]  s_ex_op;
    logic [4:0]  s_ex_rd;
    logic        s_ex_reg_write, s_ex_mem_read, s_ex_mem_write;
    logic [1:0]  s_stall_count;

    int checks_run    = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_use_rs2(id_use_rs2), .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_a(ex_a),
        .ex_b(ex_b), .ex_op(ex_op), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .stall_count(stall_count)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(s_id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_use_rs2(id_use_rs2), .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .ex_ready(ex_ready), .ex_valid(s_ex_valid), .ex_a(s_ex_a),
        .ex_b(s_ex_b), .ex_op(s_ex_op), .ex_store_data(s_ex_store_data), .ex_rd(s_ex_rd),
        .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
        .ex_mem_write(s_ex_mem_write), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_result(wb_result), .stall_count(s_stall_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_run++;
        if (got === exp) begin
            checks_passed++;
            $display("check %-16s got %0h expected %0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-16s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2, input logic use_rs2,
                          input logic [31:0] imm, input logic use_imm, input logic [2:0] op,
                          input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
        id_valid     = 1'b1;
        id_rs1       = rs1;
        id_rs1_data  = d1;
        id_rs2       = rs2;
        id_rs2_data  = d2;
        id_use_rs2   = use_rs2;
        id_imm       = imm;
        id_use_imm   = use_imm;
        id_alu_op    = op;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
        set_id(5'd1, 32'd5, 5'd2, 32'd7, 1'b1, 32'd0, 1'b0, 3'b010, 5'd3, 1'b1, 1'b0, 1'b0);

        // Reset held two cycles with id_valid asserted
        sample();
        check("rst_ready_c1", id_ready, 0);
        tick();
        sample();
        check("rst_ready_c2", id_ready, 0);
        check("rst_valid", ex_valid, 0);
        check("rst_stall", stall_count, 0);
        check("rst_stall_sat", s_stall_count, 0);
        tick();
        rst = 1'b0;

        // Back-to-back add then sub with MEM forwarding of x3
        sample();
        check("b2b_ready", id_ready, 1);
        tick();
        set_id(5'd3, 32'd0, 5'd1, 32'd5, 1'b1, 32'd0, 1'b0, 3'b110, 5'd4, 1'b1, 1'b0, 1'b0);
        sample();
        check("add_valid", ex_valid, 1);
        check("add_a", ex_a, 5);
        check("add_b", ex_b, 7);
        check("add_op", ex_op, 3'b010);
        check("add_next_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'd12;
        sample();
        check("sub_a_fwd", ex_a, 12);
        check("sub_b", ex_b, 5);
        check("sub_op", ex_op, 3'b110);
        check("sub_rd", ex_rd, 4);
        tick();
        mem_reg_write = 1'b0;
        sample();
        check("drain_valid", ex_valid, 0);
        check("drain_a_zero", ex_a, 0);

        // Load-use: lw x5 then add x6 = x5 + x0
        set_id(5'd1, 32'd100, 5'd0, 32'd0, 1'b0, 32'd4, 1'b1, 3'b010, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd5, 32'd0, 5'd0, 32'd0, 1'b1, 32'd0, 1'b0, 3'b010, 5'd6, 1'b1, 1'b0, 1'b0);
        sample();
        check("lw_valid", ex_valid, 1);
        check("lw_mem_read", ex_mem_read, 1);
        check("lw_a", ex_a, 100);
        check("lw_b_imm", ex_b, 4);
        check("lu_ready", id_ready, 0);
        tick();
        sample();
        check("lu_bubble", ex_valid, 0);
        check("lu_ready_back", id_ready, 1);
        check("lu_stall", stall_count, 1);
        tick();
        id_valid = 1'b0;
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'd77;
        sample();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_rd", ex_rd, 6);
        check("lu_add_a_wb", ex_a, 77);
        check("lu_add_b_x0", ex_b, 0);
        check("lu_stall_keep", stall_count, 1);
        tick();

        // Hold refresh; the load cycle also captures rs2 from the WB write
        wb_reg_write = 1'b1; wb_rd = 5'd2; wb_result = 32'h99;
        set_id(5'd1, 32'h11, 5'd2, 32'h22, 1'b1, 32'd0, 1'b0, 3'b000, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        wb_rd = 5'd1; wb_result = 32'hDEAD;
        sample();
        check("hold_a_c1", ex_a, 32'hDEAD);
        check("hold_b_capt", ex_b, 32'h99);
        check("hold_ready", id_ready, 0);
        tick();
        wb_reg_write = 1'b0;
        sample();
        check("hold_a_c2", ex_a, 32'hDEAD);
        tick();
        sample();
        check("hold_a_c3", ex_a, 32'hDEAD);
        check("hold_valid", ex_valid, 1);
        tick();
        ex_ready = 1'b1;
        tick();

        // MEM over WB priority, and x0 never forwards
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'h33;
        set_id(5'd0, 32'd0, 5'd2, 32'h50, 1'b1, 32'd0, 1'b0, 3'b001, 5'd8, 1'b1, 1'b0, 1'b1);
        tick();
        id_valid = 1'b0;
        mem_reg_write = 1'b1; mem_rd = 5'd2; mem_result = 32'd9;
        wb_reg_write = 1'b1;  wb_rd = 5'd2;  wb_result = 32'd4;
        sample();
        check("prio_b_mem", ex_b, 9);
        check("prio_store", ex_store_data, 9);
        check("st_mem_write", ex_mem_write, 1);
        mem_rd = 5'd0; wb_reg_write = 1'b0;
        #1;
        check("x0_a_stored", ex_a, 0);
        check("x0_b_stored", ex_b, 32'h50);
        tick();
        mem_reg_write = 1'b0;

        // Flush while holding an instruction with another one offered
        set_id(5'd1, 32'h10, 5'd0, 32'd0, 1'b0, 32'd1, 1'b1, 3'b010, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(5'd1, 32'h20, 5'd0, 32'd0, 1'b0, 32'd2, 1'b1, 3'b010, 5'd10, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        sample();
        check("fl_ready", id_ready, 0);
        check("fl_rd_before", ex_rd, 9);
        tick();
        flush = 1'b0; id_valid = 1'b0;
        sample();
        check("fl_valid", ex_valid, 0);
        check("fl_rd_zero", ex_rd, 0);
        tick();
        sample();
        check("fl_dropped", ex_valid, 0);

        // Five hazard cycles: 16-bit counter reaches 6, 2-bit counter saturates at 3
        set_id(5'd1, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 3'b010, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        ex_ready = 1'b0;
        set_id(5'd5, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 3'b010, 5'd6, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sample();
            check($sformatf("hz_ready_%0d", i), id_ready, 0);
            tick();
        end
        sample();
        check("hz_stall", stall_count, 6);
        check("hz_stall_sat", s_stall_count, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        sample();
        check("hz_fl_valid", ex_valid, 0);
        check("hz_fl_stall", stall_count, 6);
        check("hz_fl_stall_sat", s_stall_count, 3);

        $display("%0d/%0d checks passed", checks_passed, checks_run);
        $finish;
    end

endmodule
